// File: rtl/mmv_traffic_checker.sv
// Memory-mapped traffic master: writes a seed+address pattern, reads it back
// with up to RDDEPTH reads in flight and counts in-order response mismatches.
module mmv_traffic_checker #(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 16,
  parameter int CWIDTH  = 16,
  parameter int RDDEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctl_start,
  input  logic [1:0]        ctl_mode,
  input  logic [AWIDTH-1:0] ctl_base,
  input  logic [CWIDTH-1:0] ctl_count,
  input  logic [DWIDTH-1:0] ctl_seed,
  output logic              ctl_busy,
  output logic              ctl_done,
  output logic [15:0]       stat_errors,
  output logic [AWIDTH-1:0] stat_err_addr,
  output logic              stat_unexp,
  output logic [AWIDTH-1:0] m_addr,
  output logic              m_wreq,
  output logic [DWIDTH-1:0] m_wdat,
  output logic              m_rreq,
  input  logic [DWIDTH-1:0] m_rdat,
  input  logic              m_rval,
  input  logic              m_busy
);

  localparam int PW = $clog2(RDDEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_r;
  logic [CWIDTH-1:0] cnt_r;
  logic [CWIDTH-1:0] count_r;
  logic              wr_only_r;
  logic [AWIDTH-1:0] base_r;
  logic [DWIDTH-1:0] seed_r;
  logic [AWIDTH-1:0] fifo_r [RDDEPTH];
  logic [PW-1:0]     wptr_r;
  logic [PW-1:0]     rptr_r;
  logic [PW:0]       occ_r;

  logic              start_acc_s;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;
  logic [PW:0]       occ_nxt_s;
  logic              rd_ok_s;
  logic              last_s;
  logic [AWIDTH-1:0] addr_inc_s;
  logic              mismatch_s;

  function automatic logic [DWIDTH-1:0] pat(input logic [DWIDTH-1:0] seed,
                                            input logic [AWIDTH-1:0] a);
    return seed + DWIDTH'(a);
  endfunction

  // Handshake, queue occupancy and response compare
  always_comb begin
    start_acc_s = ctl_start & ~ctl_busy;
    accept_s    = (m_wreq | m_rreq) & ~m_busy;
    push_s      = m_rreq & ~m_busy;
    pop_s       = m_rval & (occ_r != '0);
    occ_nxt_s   = occ_r + (PW+1)'(push_s) - (PW+1)'(pop_s);
    rd_ok_s     = occ_nxt_s < (PW+1)'(RDDEPTH);
    last_s      = (cnt_r == CWIDTH'(1));
    addr_inc_s  = m_addr + AWIDTH'(1);
    mismatch_s  = pop_s & (m_rdat != pat(seed_r, fifo_r[rptr_r]));
  end

  // Sequencer FSM with registered bus and control outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      count_r   <= '0;
      wr_only_r <= 1'b0;
      base_r    <= '0;
      seed_r    <= '0;
      ctl_busy  <= 1'b0;
      ctl_done  <= 1'b0;
      m_addr    <= '0;
      m_wreq    <= 1'b0;
      m_wdat    <= '0;
      m_rreq    <= 1'b0;
    end else begin
      ctl_done <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (start_acc_s) begin
            seed_r    <= ctl_seed;
            base_r    <= ctl_base;
            count_r   <= ctl_count;
            cnt_r     <= ctl_count;
            wr_only_r <= (ctl_mode == 2'd0);
            ctl_busy  <= 1'b1;
            m_addr    <= ctl_base;
            // An empty run passes through DRAIN so ctl_done lands two cycles after start
            if (ctl_count == '0) begin
              state_r <= DRAIN;
            end else if (ctl_mode == 2'd1) begin
              state_r <= READ;
              m_rreq  <= rd_ok_s;
            end else begin
              state_r <= WRITE;
              m_wreq  <= 1'b1;
              m_wdat  <= pat(ctl_seed, ctl_base);
            end
          end else begin
            state_r <= IDLE;
          end
        end
        WRITE: begin
          if (accept_s) begin
            if (last_s) begin
              m_wreq <= 1'b0;
              if (wr_only_r) begin
                state_r  <= DONE;
                ctl_done <= 1'b1;
                ctl_busy <= 1'b0;
              end else begin
                state_r <= READ;
                cnt_r   <= count_r;
                m_addr  <= base_r;
                m_rreq  <= rd_ok_s;
              end
            end else begin
              cnt_r  <= cnt_r - CWIDTH'(1);
              m_addr <= addr_inc_s;
              m_wdat <= pat(seed_r, addr_inc_s);
            end
          end
        end
        READ: begin
          if (push_s) begin
            cnt_r  <= cnt_r - CWIDTH'(1);
            m_addr <= addr_inc_s;
            if (last_s) begin
              m_rreq  <= 1'b0;
              state_r <= DRAIN;
            end else begin
              m_rreq <= rd_ok_s;
            end
          end else if (!m_rreq) begin
            m_rreq <= rd_ok_s;
          end
        end
        DRAIN: begin
          if (occ_nxt_s == '0) begin
            state_r  <= DONE;
            ctl_done <= 1'b1;
            ctl_busy <= 1'b0;
          end
        end
        default: begin
          state_r  <= IDLE;
          ctl_busy <= 1'b0;
          m_wreq   <= 1'b0;
          m_rreq   <= 1'b0;
        end
      endcase
    end
  end

  // Outstanding-read address storage
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      fifo_r[wptr_r] <= m_addr;
    end
  end

  // Queue pointers and sticky statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_r        <= '0;
      rptr_r        <= '0;
      occ_r         <= '0;
      stat_errors   <= 16'h0000;
      stat_err_addr <= '0;
      stat_unexp    <= 1'b0;
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + PW'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PW'(1);
      end
      occ_r <= occ_nxt_s;
      if (start_acc_s) begin
        stat_errors   <= 16'h0000;
        stat_err_addr <= '0;
        stat_unexp    <= 1'b0;
      end else begin
        if (m_rval && occ_r == '0) begin
          stat_unexp <= 1'b1;
        end
        if (mismatch_s) begin
          if (stat_errors != 16'hFFFF) begin
            stat_errors <= stat_errors + 16'h0001;
          end
          if (stat_errors == 16'h0000) begin
            stat_err_addr <= fifo_r[rptr_r];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mmv_traffic_checker.sv
// Directed and randomized bench for mmv_traffic_checker with a behavioural
// memory slave and a transaction-list reference model.
module tb_mmv_traffic_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ctl_start = 1'b0;
  logic [1:0]  ctl_mode = 2'd0;
  logic [15:0] ctl_base = 16'h0;
  logic [15:0] ctl_count = 16'h0;
  logic [31:0] ctl_seed = 32'h0;
  logic        ctl_busy, ctl_done, stat_unexp, m_wreq, m_rreq;
  logic [15:0] stat_errors, stat_err_addr, m_addr;
  logic [31:0] m_wdat;
  logic [31:0] m_rdat = 32'h0;
  logic        m_rval = 1'b0;
  logic        m_busy = 1'b0;

  mmv_traffic_checker dut (
    .clk(clk), .reset(reset), .ctl_start(ctl_start), .ctl_mode(ctl_mode),
    .ctl_base(ctl_base), .ctl_count(ctl_count), .ctl_seed(ctl_seed),
    .ctl_busy(ctl_busy), .ctl_done(ctl_done), .stat_errors(stat_errors),
    .stat_err_addr(stat_err_addr), .stat_unexp(stat_unexp), .m_addr(m_addr),
    .m_wreq(m_wreq), .m_wdat(m_wdat), .m_rreq(m_rreq), .m_rdat(m_rdat),
    .m_rval(m_rval), .m_busy(m_busy)
  );

  always #5 clk = ~clk;

  typedef struct {logic [15:0] a; int due;} rsp_t;

  logic [31:0] mem [0:65535];
  rsp_t        rq[$];
  logic [15:0] wr_a[$], rd_a[$], crpt[$];
  logic [31:0] wr_d[$];
  int          wr_cyc[$];
  int cyc = 0, lat = 1, busy_pct = 0;
  bit unsol = 1'b0, gap_en = 1'b0, hold = 1'b0;
  int outst = 0, max_out = 0, stab_err = 0, both_err = 0, gap_err = 0;
  int rd_exp = 0, rsp_cnt = 0, last_rsp_cyc = 0, done_cyc = 0, start_cyc = 0;
  logic [49:0] prev_req;
  int total = 0, bad = 0;

  // Slave model and bus monitor: drive this cycle's inputs, then log what the DUT presents
  always @(negedge clk) begin
    rsp_t h;
    cyc++;
    m_busy = (busy_pct > 0) && ($urandom_range(0, 99) < busy_pct);
    m_rval = 1'b0;
    m_rdat = 32'h0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      h = rq.pop_front();
      m_rval = 1'b1;
      m_rdat = mem[h.a];
      foreach (crpt[i]) if (crpt[i] == h.a) m_rdat = m_rdat ^ 32'h0000_0100;
    end else if (unsol) begin
      m_rval = 1'b1;
      m_rdat = $urandom;
      unsol = 1'b0;
    end
    if (m_wreq && m_rreq) both_err++;
    if (hold && prev_req != {m_addr, m_wdat, m_wreq, m_rreq}) stab_err++;
    hold = (m_wreq || m_rreq) && m_busy && !reset;
    prev_req = {m_addr, m_wdat, m_wreq, m_rreq};
    if (ctl_start && !ctl_busy) start_cyc = cyc;
    if (gap_en && !m_rreq && outst < 8 && rd_a.size() > 0 && rd_a.size() < rd_exp) gap_err++;
    if (!reset && m_wreq && !m_busy) begin
      mem[m_addr] = m_wdat;
      wr_a.push_back(m_addr);
      wr_d.push_back(m_wdat);
      wr_cyc.push_back(cyc);
    end
    if (!reset && m_rreq && !m_busy) begin
      rd_a.push_back(m_addr);
      rq.push_back('{m_addr, cyc + lat});
      outst++;
    end
    if (m_rval) begin
      rsp_cnt++;
      last_rsp_cyc = cyc;
      if (outst > 0) outst--;
    end
    if (outst > max_out) max_out = outst;
    if (ctl_done) done_cyc = cyc;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_a.delete(); wr_d.delete(); rd_a.delete(); wr_cyc.delete(); crpt.delete();
    max_out = outst; stab_err = 0; both_err = 0; gap_err = 0; rsp_cnt = 0;
  endtask

  task automatic fill_pattern(input logic [15:0] base, input int n, input logic [31:0] seed);
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + 16'(i);
      mem[a] = seed + {16'h0, a};
    end
  endtask

  // Start a run and wait for ctl_done; k = clock edges from start assertion to done
  task automatic run(input string tag, input logic [1:0] mode, input logic [15:0] base,
                     input logic [15:0] count, input logic [31:0] seed, output int k);
    step();
    ctl_mode = mode; ctl_base = base; ctl_count = count; ctl_seed = seed;
    ctl_start = 1'b1;
    step();
    ctl_start = 1'b0;
    k = 1;
    chk({tag, "_busy"}, ctl_busy, 1);
    while (!ctl_done && k < 3000) begin
      step();
      k++;
    end
    chk({tag, "_done_seen"}, ctl_done, 1);
    step();
  endtask

  task automatic check_writes(input string tag, input logic [15:0] base, input int n,
                              input logic [31:0] seed);
    bit ok;
    logic [15:0] a;
    ok = (wr_a.size() == n);
    for (int i = 0; ok && i < n; i++) begin
      a = base + 16'(i);
      if (wr_a[i] !== a || wr_d[i] !== seed + {16'h0, a}) ok = 1'b0;
    end
    chk({tag, "_writes"}, ok, 1);
  endtask

  task automatic check_reads(input string tag, input logic [15:0] base, input int n);
    bit ok;
    ok = (rd_a.size() == n);
    for (int i = 0; ok && i < n; i++) begin
      if (rd_a[i] !== base + 16'(i)) ok = 1'b0;
    end
    chk({tag, "_reads"}, ok, 1);
  endtask

  initial begin
    int k, n, mode, nerr;
    logic [15:0] base, first_bad, a;
    logic [31:0] seed;

    // Reset state
    repeat (3) step();
    chk("reset_outs", {ctl_busy, ctl_done, stat_errors, stat_err_addr, stat_unexp,
                       m_addr, m_wreq, m_rreq}, 64'h0);
    chk("reset_wdat", m_wdat, 0);
    reset = 1'b0;
    step();

    // Zero-wait slave, write then read-check
    clear_logs(); lat = 1;
    run("t1", 2'd2, 16'h0010, 16'd4, 32'h100, k);
    check_writes("t1", 16'h0010, 4, 32'h100);
    chk("t1_wr_consec", wr_cyc[3] - wr_cyc[0], 3);
    chk("t1_first_lat", wr_cyc[0] - start_cyc, 1);
    check_reads("t1", 16'h0010, 4);
    chk("t1_rsp", rsp_cnt, 4);
    chk("t1_done_after_rsp", done_cyc - last_rsp_cyc, 1);
    chk("t1_errors", stat_errors, 0);
    chk("t1_unexp", stat_unexp, 0);

    // Long read latency: outstanding limit and immediate resume
    clear_logs(); lat = 20; seed = $urandom;
    fill_pattern(16'h0200, 32, seed);
    gap_en = 1'b1; rd_exp = 32;
    run("t2", 2'd1, 16'h0200, 16'd32, seed, k);
    gap_en = 1'b0;
    chk("t2_max_out", max_out, 8);
    chk("t2_gaps", gap_err, 0);
    check_reads("t2", 16'h0200, 32);
    chk("t2_rsp", rsp_cnt, 32);
    chk("t2_errors", stat_errors, 0);

    // Random stalls during writes, address wrap
    clear_logs(); lat = 1; busy_pct = 50; seed = $urandom;
    run("t3", 2'd0, 16'hFFFE, 16'd4, seed, k);
    busy_pct = 0;
    check_writes("t3", 16'hFFFE, 4, seed);
    chk("t3_stable", stab_err, 0);
    chk("t3_no_reads", rd_a.size(), 0);

    // Corrupted responses at 0x12 and 0x15
    clear_logs(); lat = 3;
    crpt.push_back(16'h0012); crpt.push_back(16'h0015);
    run("t4", 2'd3, 16'h0010, 16'd8, 32'h100, k);
    chk("t4_errors", stat_errors, 2);
    chk("t4_err_addr", stat_err_addr, 16'h0012);
    crpt.delete();
    run("t4b", 2'd2, 16'h0000, 16'd0, 32'h0, k);
    chk("t4_clear_err", stat_errors, 0);
    chk("t4_clear_addr", stat_err_addr, 0);

    // Unsolicited response in IDLE, then an empty run
    clear_logs();
    unsol = 1'b1;
    repeat (3) step();
    chk("t5_unexp", stat_unexp, 1);
    chk("t5_errors", stat_errors, 0);
    run("t5", 2'd2, 16'h0040, 16'd0, 32'h5, k);
    chk("t5_done_lat", k, 2);
    chk("t5_no_req", wr_a.size() + rd_a.size(), 0);
    chk("t5_unexp_clr", stat_unexp, 0);

    // Reset while five reads are outstanding
    clear_logs(); lat = 40; seed = $urandom;
    fill_pattern(16'h0300, 32, seed);
    step();
    ctl_mode = 2'd1; ctl_base = 16'h0300; ctl_count = 16'd32; ctl_seed = seed;
    ctl_start = 1'b1;
    step();
    ctl_start = 1'b0;
    k = 0;
    while (outst < 5 && k < 100) begin
      step();
      k++;
    end
    chk("t6_outst", outst, 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_outs_zero", {ctl_busy, ctl_done, stat_errors, stat_err_addr, stat_unexp,
                         m_addr, m_wreq, m_rreq}, 64'h0);
    chk("t6_wdat_zero", m_wdat, 0);
    k = 0;
    while (rq.size() > 0 && k < 200) begin
      step();
      k++;
    end
    step(); step();
    chk("t6_late_unexp", stat_unexp, 1);
    chk("t6_late_errors", stat_errors, 0);
    clear_logs(); lat = 2;
    run("t6", 2'd2, 16'h0040, 16'd6, 32'hABCD0000, k);
    check_writes("t6", 16'h0040, 6, 32'hABCD0000);
    check_reads("t6", 16'h0040, 6);
    chk("t6_errors", stat_errors, 0);
    chk("t6_unexp", stat_unexp, 0);

    // Randomized runs against the transaction-list model
    for (int r = 0; r < 5; r++) begin
      clear_logs();
      mode = $urandom_range(0, 3);
      base = 16'($urandom);
      n = $urandom_range(1, 40);
      seed = $urandom;
      busy_pct = $urandom_range(0, 60);
      lat = $urandom_range(1, 12);
      fill_pattern(base, n, seed);
      if (mode != 0 && $urandom_range(0, 1) == 1) begin
        a = base + 16'($urandom_range(0, n - 1));
        crpt.push_back(a);
      end
      nerr = (mode != 0) ? crpt.size() : 0;
      first_bad = (nerr > 0) ? crpt[0] : 16'h0;
      run("rnd", 2'(mode), base, 16'(n), seed, k);
      check_writes("rnd", base, (mode != 1) ? n : 0, seed);
      check_reads("rnd", base, (mode != 0) ? n : 0);
      chk("rnd_errors", stat_errors, nerr);
      chk("rnd_err_addr", stat_err_addr, first_bad);
      chk("rnd_unexp", stat_unexp, 0);
      chk("rnd_stable", stab_err, 0);
      chk("rnd_exclusive", both_err, 0);
      chk("rnd_max_out", max_out <= 8, 1);
    end
    busy_pct = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
